// File: rtl/atomrvcore_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : atomrvcore_lsu_pkg
// Brief    : Shared types, access-size codes and decode helpers for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package atomrvcore_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_cause_e;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  function automatic logic f3_illegal(input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: bad = 1'b0;
      default:                        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/atomrvcore_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_lsu_align
// Brief    : Combinational lane steering: store byte enables / replicated
//            write data, and load byte/half extraction with sign/zero extend.
// Revision : 1.0 - initial release
// ============================================================================
module atomrvcore_lsu_align
  import atomrvcore_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_rs2;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rs2[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Halfword accesses are already known aligned, so only addr[1] selects.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'b0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'b0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/atomrvcore_lsu.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_lsu
// Brief    : Execute-stage load/store unit on a req/gnt/rvalid data port with
//            one registered writeback beat per instruction.
// Options  : ATOMRVCORE_LSU_TIMEOUT_EN adds a gnt/rvalid wait watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module atomrvcore_lsu
  import atomrvcore_lsu_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int ADDRWIDTH      = 32,
  parameter int REGADDR        = 5,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           mem_op_i,
  input  logic [2:0]           funct3_i,
  input  logic [DATAWIDTH-1:0] alu_result_i,
  input  logic [DATAWIDTH-1:0] rs2_data_i,
  input  logic [REGADDR-1:0]   rd_i,
  input  logic                 rd_we_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [ADDRWIDTH-1:0] addr_o,
  output logic [3:0]           be_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [DATAWIDTH-1:0] rdata_i,
  output logic                 wb_valid_o,
  output logic                 wb_we_o,
  output logic [REGADDR-1:0]   wb_rd_o,
  output logic [DATAWIDTH-1:0] wb_data_o,
  output logic                 err_o,
  output logic [1:0]           err_cause_o
);

  lsu_state_e             r_state;
  lsu_state_e             w_state_next;

  logic                   r_is_store;
  logic [2:0]             r_funct3;
  logic [ADDRWIDTH-1:0]   r_addr;
  logic [DATAWIDTH-1:0]   r_rs2;
  logic [REGADDR-1:0]     r_rd;
  logic                   r_rd_we;

  logic                   r_wb_valid;
  logic                   r_wb_we;
  logic [REGADDR-1:0]     r_wb_rd;
  logic [DATAWIDTH-1:0]   r_wb_data;
  logic                   r_err;
  err_cause_e             r_err_cause;

  logic                   w_accept;
  logic                   w_is_mem;
  logic                   w_f3_bad;
  logic                   w_misal;
  logic                   w_issue;
  logic                   w_timeout;
  logic                   w_in_req;
  logic [3:0]             w_be;
  logic [DATAWIDTH-1:0]   w_wdata;
  logic [DATAWIDTH-1:0]   w_load_data;

  assign w_accept = valid_i && (r_state == LSU_IDLE);
  assign w_is_mem = (mem_op_e'(mem_op_i) == MEM_LOAD) || (mem_op_e'(mem_op_i) == MEM_STORE);
  assign w_f3_bad = f3_illegal(funct3_i);
  assign w_misal  = addr_misaligned(funct3_i, alu_result_i[1:0]);
  assign w_issue  = w_accept && w_is_mem && !w_f3_bad && !w_misal;
  assign w_in_req = (r_state == LSU_REQ);

  atomrvcore_lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr[1:0]),
    .i_rs2       (r_rs2),
    .i_rdata     (rdata_i),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

`ifdef ATOMRVCORE_LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  // Counts completed cycles in the current wait state; restarts on every state change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_tmo_cnt <= '0;
    end else if (r_state != LSU_IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);
  assign w_timeout = w_tmo_hit &&
                     ((w_in_req && !gnt_i) || ((r_state == LSU_WAIT) && !rvalid_i));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_issue) w_state_next = LSU_REQ;
      end
      LSU_REQ: begin
        if (gnt_i)          w_state_next = LSU_WAIT;
        else if (w_timeout) w_state_next = LSU_IDLE;
      end
      LSU_WAIT: begin
        if (rvalid_i || w_timeout) w_state_next = LSU_IDLE;
      end
      default: w_state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_is_store <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
    end else if (w_accept) begin
      r_is_store <= (mem_op_e'(mem_op_i) == MEM_STORE);
      r_funct3   <= funct3_i;
      r_addr     <= alu_result_i[ADDRWIDTH-1:0];
      r_rs2      <= rs2_data_i;
      r_rd       <= rd_i;
      r_rd_we    <= rd_we_i;
    end
  end

  // Writeback fields are zero whenever no beat is presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_err_cause <= ERR_NONE;
    end else begin
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_err_cause <= ERR_NONE;
      if (w_accept && !w_is_mem) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= rd_we_i;
        r_wb_rd    <= rd_i;
        r_wb_data  <= alu_result_i;
      end else if (w_accept && (w_f3_bad || w_misal)) begin
        r_wb_valid  <= 1'b1;
        r_wb_rd     <= rd_i;
        r_err       <= 1'b1;
        r_err_cause <= w_f3_bad ? ERR_FUNCT3 : ERR_MISALIGN;
      end else if ((r_state == LSU_WAIT) && rvalid_i) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_we    <= r_is_store ? 1'b0 : r_rd_we;
        r_wb_data  <= r_is_store ? '0 : w_load_data;
      end else if (w_timeout) begin
        r_wb_valid  <= 1'b1;
        r_wb_rd     <= r_rd;
        r_err       <= 1'b1;
        r_err_cause <= ERR_TIMEOUT;
      end
    end
  end

  assign ready_o     = (r_state == LSU_IDLE);
  assign req_o       = w_in_req;
  assign we_o        = w_in_req && r_is_store;
  assign addr_o      = w_in_req ? {r_addr[ADDRWIDTH-1:2], 2'b00} : '0;
  assign be_o        = w_in_req ? w_be : 4'b0000;
  assign wdata_o     = w_in_req ? w_wdata : '0;

  assign wb_valid_o  = r_wb_valid;
  assign wb_we_o     = r_wb_we;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign err_o       = r_err;
  assign err_cause_o = r_err_cause;

endmodule
`default_nettype wire

// File: tb/tb_atomrvcore_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_atomrvcore_lsu
// Brief    : Directed self-checking bench for atomrvcore_lsu (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_atomrvcore_lsu;

  logic        clk_i        = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        valid_i      = 1'b0;
  logic        ready_o;
  logic [1:0]  mem_op_i     = 2'b00;
  logic [2:0]  funct3_i     = 3'b000;
  logic [31:0] alu_result_i = '0;
  logic [31:0] rs2_data_i   = '0;
  logic [4:0]  rd_i         = '0;
  logic        rd_we_i      = 1'b0;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        gnt_i        = 1'b0;
  logic        rvalid_i     = 1'b0;
  logic [31:0] rdata_i      = '0;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;
  logic [1:0]  err_cause_o;

  int n_checks = 0;
  int n_errors = 0;

  atomrvcore_lsu dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mem_op_i     (mem_op_i),
    .funct3_i     (funct3_i),
    .alu_result_i (alu_result_i),
    .rs2_data_i   (rs2_data_i),
    .rd_i         (rd_i),
    .rd_we_i      (rd_we_i),
    .req_o        (req_o),
    .we_o         (we_o),
    .addr_o       (addr_o),
    .be_o         (be_o),
    .wdata_o      (wdata_o),
    .gnt_i        (gnt_i),
    .rvalid_i     (rvalid_i),
    .rdata_i      (rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_we_o      (wb_we_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .err_o        (err_o),
    .err_cause_o  (err_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Aligned load/store with programmable gnt and rvalid delays (cycles).
  task automatic mem_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb);
    valid_i = 1'b1; mem_op_i = op; funct3_i = f3; alu_result_i = addr;
    rs2_data_i = rs2; rd_i = 5'd9; rd_we_i = 1'b1;
    check_eq({tag, "_ready_idle"}, ready_o, 1'b1);
    step();
    valid_i = 1'b0;
    for (int k = 0; k <= gnt_dly; k++) begin
      check_eq({tag, "_req"}, req_o, 1'b1);
      check_eq({tag, "_ready_busy"}, ready_o, 1'b0);
      check_eq({tag, "_addr"}, addr_o, {addr[31:2], 2'b00});
      check_eq({tag, "_be"}, be_o, exp_be);
      check_eq({tag, "_we"}, we_o, (op == 2'b10));
      if (op == 2'b10) check_eq({tag, "_wdata"}, wdata_o, exp_wdata);
      gnt_i = (k == gnt_dly);
      step();
    end
    gnt_i = 1'b0;
    check_eq({tag, "_req_wait"}, req_o, 1'b0);
    for (int k = 0; k <= rv_dly; k++) begin
      check_eq({tag, "_no_wb_early"}, wb_valid_o, 1'b0);
      rvalid_i = (k == rv_dly);
      rdata_i  = rdata;
      step();
    end
    rvalid_i = 1'b0;
    check_eq({tag, "_wb_valid"}, wb_valid_o, 1'b1);
    check_eq({tag, "_wb_we"}, wb_we_o, (op == 2'b01));
    check_eq({tag, "_err"}, err_o, 1'b0);
    if (op == 2'b01) begin
      check_eq({tag, "_wb_data"}, wb_data_o, exp_wb);
      check_eq({tag, "_wb_rd"}, wb_rd_o, 5'd9);
    end
    step();
    check_eq({tag, "_pulse_end"}, wb_valid_o, 1'b0);
  endtask

  task automatic err_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [1:0] exp_cause);
    valid_i = 1'b1; mem_op_i = op; funct3_i = f3; alu_result_i = addr; rd_i = 5'd4; rd_we_i = 1'b1;
    step();
    valid_i = 1'b0;
    check_eq({tag, "_no_req"}, req_o, 1'b0);
    check_eq({tag, "_ready"}, ready_o, 1'b1);
    check_eq({tag, "_wb_valid"}, wb_valid_o, 1'b1);
    check_eq({tag, "_wb_we"}, wb_we_o, 1'b0);
    check_eq({tag, "_err"}, err_o, 1'b1);
    check_eq({tag, "_cause"}, err_cause_o, exp_cause);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check_eq("rst_ready", ready_o, 1'b1);
    check_eq("rst_req", req_o, 1'b0);
    check_eq("rst_wb_valid", wb_valid_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_cause", err_cause_o, 2'b00);
    check_eq("rst_addr", addr_o, 32'h0);
    check_eq("rst_be", be_o, 4'h0);
    step();
    step();
    rst_ni = 1'b1;

    // Passthrough, three back-to-back (third uses reserved mem_op).
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; mem_op_i = (i == 2) ? 2'b11 : 2'b00; funct3_i = 3'b011;
      alu_result_i = 32'h0000_1234 + i; rd_i = 5'(5 + i); rd_we_i = 1'b1;
      step();
      check_eq("pt_wb_valid", wb_valid_o, 1'b1);
      check_eq("pt_wb_data", wb_data_o, 32'h0000_1234 + i);
      check_eq("pt_wb_rd", wb_rd_o, 5 + i);
      check_eq("pt_wb_we", wb_we_o, 1'b1);
      check_eq("pt_err", err_o, 1'b0);
      check_eq("pt_no_req", req_o, 1'b0);
    end
    valid_i = 1'b0;
    step();
    check_eq("pt_idle", wb_valid_o, 1'b0);

    // rvalid outside WAIT must be ignored.
    rvalid_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
    step();
    rvalid_i = 1'b0;
    check_eq("rvalid_idle_ignored", wb_valid_o, 1'b0);

    mem_txn("lb",  2'b01, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_FFFF, 0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    mem_txn("sh",  2'b10, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         4, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    mem_txn("lh",  2'b01, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_1234, 1, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
    mem_txn("lhu", 2'b01, 3'b101, 32'h0000_0102, 32'h0,         32'h8001_1234, 0, 1, 4'b1100, 32'h0,         32'h0000_8001);
    mem_txn("lbu", 2'b01, 3'b100, 32'h0000_0101, 32'h0,         32'h1234_F078, 0, 0, 4'b0010, 32'h0,         32'h0000_00F0);
    mem_txn("lw",  2'b01, 3'b010, 32'h0000_0200, 32'h0,         32'hCAFE_BABE, 2, 2, 4'b1111, 32'h0,         32'hCAFE_BABE);
    mem_txn("sb",  2'b10, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,         0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    mem_txn("sw",  2'b10, 3'b010, 32'h0000_0404, 32'h0123_4567, 32'h0,         1, 0, 4'b1111, 32'h0123_4567, 32'h0);

    err_txn("mis_lw",   2'b01, 3'b010, 32'h0000_3001, 2'b01);
    err_txn("mis_sh",   2'b10, 3'b101, 32'h0000_3003, 2'b01);
    err_txn("ill_lh",   2'b01, 3'b011, 32'h0000_3000, 2'b10);
    err_txn("ill_prio", 2'b10, 3'b111, 32'h0000_3001, 2'b10);

    // Reset while in WAIT: immediate idle, late response discarded.
    valid_i = 1'b1; mem_op_i = 2'b01; funct3_i = 3'b010; alu_result_i = 32'h0000_4000;
    step();
    valid_i = 1'b0; gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    check_eq("rw_ready_busy", ready_o, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rw_ready_async", ready_o, 1'b1);
    check_eq("rw_req_async", req_o, 1'b0);
    step();
    rst_ni = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'h1111_2222;
    step();
    rvalid_i = 1'b0;
    check_eq("rw_late_rvalid", wb_valid_o, 1'b0);

    // Reset while in REQ drops req_o the same instant.
    valid_i = 1'b1; mem_op_i = 2'b10; funct3_i = 3'b010; alu_result_i = 32'h0000_5000;
    step();
    valid_i = 1'b0;
    check_eq("rr_req_before", req_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rr_req_async", req_o, 1'b0);
    check_eq("rr_addr_async", addr_o, 32'h0);
    step();
    rst_ni = 1'b1;

    // Unit keeps working after reset.
    valid_i = 1'b1; mem_op_i = 2'b00; alu_result_i = 32'h0000_ABCD; rd_i = 5'd0; rd_we_i = 1'b1;
    step();
    valid_i = 1'b0;
    check_eq("post_rst_wb_valid", wb_valid_o, 1'b1);
    check_eq("post_rst_wb_data", wb_data_o, 32'h0000_ABCD);
    check_eq("post_rst_wb_we_x0", wb_we_o, 1'b1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
